// File: rtl/arima_stream_pkg.sv
// Shared state type and sizing helpers for the ARIMA BRAM streamer.
package arima_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} stream_state_e;

  localparam int unsigned RD_LAT_MAX = 3;

  // One slot per in-flight read plus the word currently presented to the core.
  function automatic int unsigned FIFO_DEPTH_OF(input int unsigned rd_lat);
    return rd_lat + 1;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small circular skid FIFO that absorbs BRAM read returns ahead of the core.
module stream_skid_fifo #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [N-1:0]  push_data,
  input  logic          pop,
  output logic [N-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LastIdx = PW'(DEPTH - 1);

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + PW'(1);
  endfunction

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= next_idx(tail_q);
      if (do_pop)  head_q <= next_idx(head_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[tail_q] <= push_data;
  end

  assign empty   = (count_q == '0);
  assign count   = count_q;
  // Drive zero when empty so the sample bus is clean out of reset.
  assign rd_data = empty ? '0 : mem_q[head_q];

endmodule

// File: rtl/arima_mem_streamer.sv
// BRAM front-end for the ARIMA core: streams samples out, writes predictions back.
// Optional starvation counter output stall_cnt is built when ARIMA_STREAM_STATS_EN is defined.
module arima_mem_streamer
  import arima_stream_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned AW      = 11,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned WB_BASE = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   num_samples,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [N-1:0]  mem_din,
  input  logic [N-1:0]  mem_dout,
  output logic          smp_valid,
  output logic [N-1:0]  smp_data,
  input  logic          smp_ready,
  input  logic          pred_valid,
  input  logic [N-1:0]  pred_data,
  output logic          pred_ready,
  output logic          busy,
  output logic          done,
`ifdef ARIMA_STREAM_STATS_EN
  output logic [31:0]   stall_cnt,
`endif
  output logic [AW:0]   sample_cnt
);

  localparam int unsigned Lat       = (RD_LAT == 0) ? 1 :
                                      (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int unsigned FifoDepth = FIFO_DEPTH_OF(Lat);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam int unsigned OccW      = CntW + 1;
  localparam int unsigned PtrW      = AW + 1;
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WbStart  = AW'(WB_BASE % DEPTH);

  stream_state_e state_q;
  logic [AW:0]     n_q, rd_ptr_q, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_addr_q, wr_addr_q;
  logic [Lat-1:0]  pipe_q, pipe_d;
  logic [CntW-1:0] fifo_cnt;
  logic [OccW-1:0] inflight, occ;
  logic            busy_q, done_q;
  logic            fifo_empty, fifo_pop, start_run, run, do_write, do_read;

  assign run        = (state_q == RUN);
  assign start_run  = (state_q == IDLE) && start;
  assign pred_ready = run && (wr_ptr_q < n_q);
  assign do_write   = pred_ready && pred_valid;
  assign smp_valid  = !fifo_empty;
  assign fifo_pop   = smp_valid && smp_ready;

  // Reserve a FIFO slot for every read still in the BRAM pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(Lat); i++) begin
      inflight = inflight + OccW'(pipe_q[i]);
    end
    occ = OccW'(fifo_cnt) + inflight - OccW'(fifo_pop);
  end

  assign do_read  = run && !do_write && (rd_ptr_q < n_q) && (occ < OccW'(FifoDepth));
  assign mem_en   = do_write || do_read;
  assign mem_we   = do_write;
  assign mem_addr = do_write ? wr_addr_q : (do_read ? rd_addr_q : '0);
  assign mem_din  = do_write ? pred_data : '0;
  assign wr_ptr_d = wr_ptr_q + PtrW'(do_write);
  assign pipe_d   = Lat'({pipe_q, do_read});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= WbStart;
      pipe_q    <= '0;
    end else begin
      pipe_q <= pipe_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q       <= num_samples;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= WbStart;
            pipe_q    <= '0;
            busy_q    <= 1'b1;
            if (num_samples == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (do_read) begin
            rd_ptr_q  <= rd_ptr_q + PtrW'(1);
            rd_addr_q <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + AW'(1);
          end
          if (do_write) begin
            wr_ptr_q  <= wr_ptr_d;
            wr_addr_q <= (wr_addr_q == LastAddr) ? '0 : wr_addr_q + AW'(1);
          end
          if (wr_ptr_d == n_q) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = wr_ptr_q;

  stream_skid_fifo #(
    .N     (N),
    .DEPTH (FifoDepth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_run),
    .push      (pipe_q[Lat-1]),
    .push_data (mem_dout),
    .pop       (fifo_pop),
    .rd_data   (smp_data),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

`ifdef ARIMA_STREAM_STATS_EN
  logic [31:0] stall_q;

  // Cycles where the core wanted a sample but none was ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (start_run) begin
      stall_q <= '0;
    end else if (run && smp_ready && !smp_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_arima_mem_streamer.sv
// Directed-random bench for arima_mem_streamer with a BRAM model and an echoing core model.
module tb_arima_mem_streamer;

  localparam int unsigned N       = 32;
  localparam int unsigned AW      = 4;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned RD_LAT  = 3;
  localparam int unsigned WB_BASE = 6;
  localparam int unsigned FD      = RD_LAT + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_samples;
  logic [AW-1:0] mem_addr;
  logic          mem_en, mem_we;
  logic [N-1:0]  mem_din, mem_dout;
  logic          smp_valid, smp_ready;
  logic [N-1:0]  smp_data;
  logic          pred_valid, pred_ready;
  logic [N-1:0]  pred_data;
  logic          busy, done;
  logic [AW:0]   sample_cnt;
`ifdef ARIMA_STREAM_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  arima_mem_streamer #(
    .N       (N),
    .AW      (AW),
    .DEPTH   (DEPTH),
    .RD_LAT  (RD_LAT),
    .WB_BASE (WB_BASE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_samples (num_samples),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .pred_valid  (pred_valid),
    .pred_data   (pred_data),
    .pred_ready  (pred_ready),
    .busy        (busy),
    .done        (done),
`ifdef ARIMA_STREAM_STATS_EN
    .stall_cnt   (stall_cnt),
`endif
    .sample_cnt  (sample_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [N-1:0] mem   [DEPTH];
  logic [N-1:0] dpipe [RD_LAT];
  logic [N-1:0] exp_smp [$];
  logic [N-1:0] exp_wr  [$];
  logic [N-1:0] pq_val  [$];
  int           pq_t    [$];
  int           issue_cyc [$];
  int rcount, wcount, accepted, returned, done_cnt, done_cyc, run_n, ready_mode;
  int stall_model;
  bit const_chk, held_valid;
  logic [N-1:0] held_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_smp.delete(); exp_wr.delete(); pq_val.delete(); pq_t.delete(); issue_cyc.delete();
    rcount = 0; wcount = 0; accepted = 0; returned = 0; done_cnt = 0; done_cyc = -1;
    held_valid = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 64'(mem_en), 0);
    check({tag, "_mem_we"}, 64'(mem_we), 0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check({tag, "_mem_din"}, 64'(mem_din), 0);
    check({tag, "_smp_valid"}, 64'(smp_valid), 0);
    check({tag, "_smp_data"}, 64'(smp_data), 0);
    check({tag, "_pred_ready"}, 64'(pred_ready), 0);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_sample_cnt"}, 64'(sample_cnt), 0);
  endtask

  // One clock cycle: drive inputs just after posedge, observe at negedge.
  task automatic cycle(input logic st, input logic [AW:0] ns);
    logic [N-1:0] rd_val, v;
    bit newrd;
    int occ;
    start = st;
    num_samples = ns;
    case (ready_mode)
      0:       smp_ready = 1'b1;
      1:       smp_ready = (cyc % 2 == 0);
      default: smp_ready = 1'($urandom_range(0, 1));
    endcase
    pred_valid = 1'b0;
    pred_data  = '0;
    if (pq_val.size() > 0 && pq_t[0] <= cyc && $urandom_range(0, 3) != 0) begin
      pred_valid = 1'b1;
      pred_data  = pq_val[0];
    end
    mem_dout = dpipe[RD_LAT-1];
    newrd = 0;
    rd_val = '0;

    @(negedge clk);
    occ = returned - accepted;
    check("fifo_bound", 64'(occ <= int'(FD)), 1);
    check("smp_valid", 64'(smp_valid), 64'(occ > 0));
    if (held_valid) begin
      check("hold_valid", 64'(smp_valid), 1);
      check("hold_data", 64'(smp_data), 64'(held_data));
    end
    held_valid = smp_valid && !smp_ready;
    held_data  = smp_data;

    if (smp_valid && smp_ready) begin
      if (exp_smp.size() == 0) begin
        check("smp_unexpected", 1, 0);
      end else begin
        v = exp_smp.pop_front();
        check("smp_data", 64'(smp_data), 64'(v));
        if (const_chk) check("smp_const", 64'(smp_data), 64'(100 + accepted));
        exp_wr.push_back(v + 1);
      end
      pq_val.push_back(smp_data + 1);
      pq_t.push_back(cyc + 2);
      accepted++;
    end

    if (pred_valid) begin
      check("pred_ready", 64'(pred_ready), 1);
      check("wr_priority", 64'(mem_en && mem_we), 1);
    end else begin
      check("no_spurious_wr", 64'(mem_en && mem_we), 0);
    end

    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      check("wr_addr", 64'(mem_addr), 64'((WB_BASE + wcount) % DEPTH));
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else check("wr_data", 64'(mem_din), 64'(exp_wr.pop_front()));
      mem[int'(mem_addr) % DEPTH] = mem_din;
      wcount++;
    end else if (mem_en === 1'b1) begin
      check("rd_addr", 64'(mem_addr), 64'(rcount % DEPTH));
      check("rd_in_range", 64'(rcount < run_n), 1);
      rd_val = mem[int'(mem_addr) % DEPTH];
      exp_smp.push_back(rd_val);
      issue_cyc.push_back(cyc);
      newrd = 1;
      rcount++;
    end

    if (pred_valid && pred_ready) begin
      void'(pq_val.pop_front());
      void'(pq_t.pop_front());
    end
    if (busy && !done && smp_ready && !smp_valid) stall_model++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_busy", 64'(busy), 1);
    end

    @(posedge clk);
    while (issue_cyc.size() > 0 && issue_cyc[0] + int'(RD_LAT) == cyc) begin
      void'(issue_cyc.pop_front());
      returned++;
    end
    for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
    dpipe[0] = newrd ? rd_val : 32'hDEAD_BEEF;
    #1;
    cyc++;
  endtask

  task automatic do_run(input int n, input int mode, input bit cchk, input int restart_at,
                        input int abort_after, output bit aborted);
    int start_cyc;
    aborted = 0;
    clear_model();
    run_n = n;
    ready_mode = mode;
    const_chk = cchk;
    check("idle_before_start", 64'(busy), 0);
    stall_model = 0;
    start_cyc = cyc;
    cycle(1'b1, (AW + 1)'(n));
    for (int k = 0; k < 400 && done_cnt == 0; k++) begin
      if (abort_after > 0 && wcount >= abort_after) begin
        aborted = 1;
        return;
      end
      cycle(k == restart_at, (AW + 1)'(n + 3));
    end
    check("done_once", 64'(done_cnt), 1);
    if (n == 0) check("done_latency", 64'(done_cyc - start_cyc), 1);
    check("after_done", 64'(done), 0);
    check("after_busy", 64'(busy), 0);
    check("sample_cnt", 64'(sample_cnt), 64'(n));
    check("reads_total", 64'(rcount), 64'(n));
    check("writes_total", 64'(wcount), 64'(n));
`ifdef ARIMA_STREAM_STATS_EN
    check("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
    cycle(1'b0, '0);
    check("sample_cnt_held", 64'(sample_cnt), 64'(n));
  endtask

  initial begin
    bit ab;
    reset = 1'b1; start = 1'b0; num_samples = '0; smp_ready = 1'b0;
    pred_valid = 1'b0; pred_data = '0; mem_dout = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'(100 + i);
    for (int i = 0; i < int'(RD_LAT); i++) dpipe[i] = '0;
    clear_model();
    #3 reset = 1'b0;
    #1 check_all_zero("por");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic stream with constant readiness; first words are the preload.
    do_run(4, 0, 1'b1, -1, 0, ab);
    // Toggling readiness with a run longer than the memory (address wrap).
    do_run(10, 1, 1'b0, -1, 0, ab);
    // Largest run the pointers must represent, random readiness.
    do_run(16, 2, 1'b0, -1, 0, ab);
    // Empty run: done the cycle after start with no port activity.
    do_run(0, 0, 1'b0, -1, 0, ab);
    // A second start while running must not change the run length.
    do_run(5, 0, 1'b0, 3, 0, ab);

    // Reset mid-run after two write-backs.
    do_run(6, 2, 1'b0, -1, 2, ab);
    check("abort_reached", 64'(ab), 1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    pred_valid = 1'b0;
    clear_model();
    @(posedge clk); #1;
    cyc++;
    do_run(3, 0, 1'b0, -1, 0, ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
